// File: rtl/digit_scan_mux.sv
// rtl/digit_scan_mux.sv - time-multiplexed 8-digit BCD scanner for a shared 7-segment bus
//
// Purpose:
//   Scans NUM_DIGITS BCD nibbles onto one decoder input (oDigit) and lights one
//   anode at a time (oAn, active-low). Each digit gets a dark BLANK slot, so the
//   segment lines can settle, and then a lit SHOW slot. New data is double-buffered
//   (hold -> shadow) and committed only on the frame wrap, so a frame never tears.
//
// Ports:
//   iClk      in   1             system clock, rising edge
//   iRst_n    in   1             asynchronous active-low reset
//   iData     in   4*NUM_DIGITS  BCD digits, nibble k = digit k (digit 0 = LSD)
//   iLoad     in   1             one-cycle strobe requesting iData for display
//   iDigitEn  in   NUM_DIGITS    per-digit enable; disabled digits keep their anode off
//   iLzb      in   1             blank leading zeros (digit 0 is never blanked)
//   oDigit    out  4             nibble for the decoder, 4'hF = blank
//   oAn       out  NUM_DIGITS    anodes, active-low, one-hot-low or all ones
//   oFrame    out  1             one-cycle pulse during the last cycle of each frame

module digit_scan_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic [4*NUM_DIGITS-1:0] iData,
  input  logic                    iLoad,
  input  logic [NUM_DIGITS-1:0]   iDigitEn,
  input  logic                    iLzb,
  output logic [3:0]              oDigit,
  output logic [NUM_DIGITS-1:0]   oAn,
  output logic                    oFrame
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      SHOW_PRE   = CNT_W'(REFRESH_DIV - 2);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  logic [0:0]              state_q,   state_d;
  logic [IDX_W-1:0]        idx_q,     idx_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q,  shadow_d;
  logic [4*NUM_DIGITS-1:0] hold_q,    hold_d;
  logic                    pending_q, pending_d;
  logic [3:0]              digit_q,   digit_d;
  logic [NUM_DIGITS-1:0]   an_q,      an_d;
  logic                    frame_q,   frame_d;

  logic last_blank;
  logic last_show;
  logic wrap;

  // Nibble k of the shadow, or blank when it is a leading zero under iLzb.
  function automatic logic [3:0] disp_nibble(input logic [4*NUM_DIGITS-1:0] sh,
                                             input logic [IDX_W-1:0]        k,
                                             input logic                    lzb);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(k) && sh[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
    if (lzb && k != '0 && upper_zero) return 4'hF;
    return sh[4*int'(k) +: 4];
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 1'b1;
    shadow_d  = shadow_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    digit_d   = digit_q;
    an_d      = an_q;

    last_blank = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
    last_show  = (state_q == ST_SHOW) && (cnt_q == SHOW_LAST);
    wrap       = last_show && (idx_q == IDX_LAST);

    if (last_blank) begin
      state_d = ST_SHOW;
      cnt_d   = '0;
    end else if (last_show) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = wrap ? '0 : idx_q + 1'b1;
    end

    // A load landing exactly on the wrap edge bypasses hold so it is not lost
    // for a whole frame.
    if (wrap) begin
      pending_d = 1'b0;
      if (iLoad) shadow_d = iData;
      else if (pending_q) shadow_d = hold_q;
    end
    if (iLoad) begin
      hold_d = iData;
      if (!wrap) pending_d = 1'b1;
    end

    // Outputs are recomputed only on state transitions; BLANK presents the
    // next digit early so segments settle before the anode turns on.
    if (last_blank || last_show) begin
      digit_d = disp_nibble(shadow_d, idx_d, iLzb);
      an_d    = (state_d == ST_SHOW && iDigitEn[idx_d]) ? ~(AN_ONE << idx_d) : '1;
    end

    // Registered one cycle early so the pulse coincides with the wrap cycle.
    frame_d = (state_q == ST_SHOW) && (idx_q == IDX_LAST) && (cnt_q == SHOW_PRE);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= ST_BLANK;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      digit_q   <= 4'hF;
      an_q      <= '1;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign oDigit = digit_q;
  assign oAn    = an_q;
  assign oFrame = frame_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb/tb_digit_scan_mux.sv - self-checking bench for digit_scan_mux
module tb_digit_scan_mux;

  localparam int N     = 8;
  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = N * SLOT;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data  = 32'h0;
  logic        load  = 1'b0;
  logic [7:0]  en    = 8'hFF;
  logic        lzb   = 1'b0;
  logic [3:0]  o_digit;
  logic [7:0]  o_an;
  logic        o_frame;

  int total  = 0;
  int passed = 0;

  // Reference model: position in the frame is derived from the clock count
  // since reset release.
  int          c;
  logic [31:0] m_shadow, m_hold;
  logic        m_pending;
  logic [3:0]  e_digit;
  logic [7:0]  e_an;
  logic        e_frame;

  logic [12:0] obs, expv;
  assign obs  = {o_digit, o_an, o_frame};
  assign expv = {e_digit, e_an, e_frame};

  digit_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .iClk(clk), .iRst_n(rst_n), .iData(data), .iLoad(load), .iDigitEn(en),
    .iLzb(lzb), .oDigit(o_digit), .oAn(o_an), .oFrame(o_frame)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_disp(logic [31:0] v, int k, logic z);
    int h;
    h = -1;
    for (int j = 0; j < N; j++) if (v[4*j +: 4] != 4'h0) h = j;
    if (z && k > 0 && k > h) return 4'hF;
    return v[4*k +: 4];
  endfunction

  task automatic model_reset;
    c = 0; m_shadow = 0; m_hold = 0; m_pending = 0;
    e_digit = 4'hF; e_an = 8'hFF; e_frame = 1'b0;
  endtask

  // Advance one clock; the model consumes the inputs present at that edge.
  task automatic tick;
    int p, off, np;
    @(posedge clk);
    if (rst_n) begin
      p = c % FRAME;
      off = p % SLOT;
      if (load) begin
        if (p == FRAME - 1) begin m_shadow = data; m_pending = 0; end
        else begin m_hold = data; m_pending = 1; end
      end else if (p == FRAME - 1) begin
        if (m_pending) m_shadow = m_hold;
        m_pending = 0;
      end
      c++;
      np = c % FRAME;
      if (off == BC - 1 || off == SLOT - 1) begin
        e_digit = ref_disp(m_shadow, np / SLOT, lzb);
        e_an = (off == BC - 1 && en[np / SLOT]) ? ~(8'h01 << (np / SLOT)) : 8'hFF;
      end
      e_frame = (np == FRAME - 1);
    end
    #1;
  endtask

  task automatic test_reset;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== 13'h1FFE) $display("FAIL reset_hold got %h want %h", obs, 13'h1FFE);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (obs !== expv) $display("FAIL reset_release got %h want %h", obs, expv);
    else passed++;
  endtask

  task automatic test_scan;
    int first_frame;
    first_frame = -1;
    for (int i = 0; i < FRAME + 8; i++) begin
      tick();
      total++;
      if (obs !== expv) $display("FAIL scan c=%0d got %h want %h", c, obs, expv);
      else passed++;
      if (o_frame && first_frame < 0) first_frame = c;
    end
    total++;
    if (first_frame !== FRAME - 1) $display("FAIL first_frame got %0d want %0d", first_frame, FRAME - 1);
    else passed++;
  endtask

  task automatic test_load;
    repeat (10) begin
      tick();
      total++;
      if (obs !== expv) $display("FAIL load_pre c=%0d got %h want %h", c, obs, expv);
      else passed++;
    end
    data = 32'h12345678; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      total++;
      if (obs !== expv) $display("FAIL load c=%0d got %h want %h", c, obs, expv);
      else passed++;
    end
  endtask

  task automatic test_lzb;
    logic [31:0] pats [2];
    pats[0] = 32'h00000450;
    pats[1] = 32'h00000000;
    lzb = 1'b1;
    for (int t = 0; t < 2; t++) begin
      data = pats[t]; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        tick();
        total++;
        if (obs !== expv) $display("FAIL lzb%0d c=%0d got %h want %h", t, c, obs, expv);
        else passed++;
      end
    end
    lzb = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    repeat (5) tick();
    data = 32'h11111111; load = 1'b1; tick(); load = 1'b0;
    repeat (3) tick();
    data = 32'h22222222; load = 1'b1; tick(); load = 1'b0;
    n = 0;
    while (!o_frame && n < 2 * FRAME) begin
      tick();
      n++;
      total++;
      if (obs !== expv) $display("FAIL b2b_wait c=%0d got %h want %h", c, obs, expv);
      else passed++;
    end
    total++;
    if (!o_frame) $display("FAIL b2b_frame_timeout got 0 want 1");
    else passed++;
    data = 32'h33333333; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < FRAME - 1; i++) begin
      total++;
      if (obs !== expv) $display("FAIL b2b c=%0d got %h want %h", c, obs, expv);
      else passed++;
      total++;
      if (o_an !== 8'hFF && o_digit !== 4'h3) $display("FAIL b2b_digit got %h want 3", o_digit);
      else passed++;
      tick();
    end
  endtask

  task automatic test_digit_en;
    int last;
    last = -1;
    en = 8'b1010_1010;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      tick();
      total++;
      if (obs !== expv) $display("FAIL en c=%0d got %h want %h", c, obs, expv);
      else passed++;
      total++;
      if ((~o_an & 8'h55) !== 8'h00) $display("FAIL en_mask got %h want no low even bits", o_an);
      else passed++;
      if (o_frame) begin
        if (last >= 0) begin
          total++;
          if (c - last !== FRAME) $display("FAIL en_frame_len got %0d want %0d", c - last, FRAME);
          else passed++;
        end
        last = c;
      end
    end
    en = 8'hFF;
  endtask

  task automatic test_random;
    for (int i = 0; i < 5 * FRAME; i++) begin
      load = ($urandom_range(0, 7) == 0);
      data = $urandom;
      if ($urandom_range(0, 15) == 0) en = 8'($urandom);
      if ($urandom_range(0, 15) == 0) lzb = 1'($urandom);
      tick();
      total++;
      if (obs !== expv) $display("FAIL rand c=%0d got %h want %h", c, obs, expv);
      else passed++;
    end
    load = 1'b0; en = 8'hFF; lzb = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    while (!o_frame && n < 2 * FRAME) begin tick(); n++; end
    tick();
    data = 32'h98765432; load = 1'b1; tick(); load = 1'b0;
    n = 0;
    while (o_an !== 8'hF7 && n < 2 * FRAME) begin
      tick();
      n++;
      total++;
      if (obs !== expv) $display("FAIL rstmid_wait c=%0d got %h want %h", c, obs, expv);
      else passed++;
    end
    total++;
    if (o_an !== 8'hF7) $display("FAIL rstmid_show3 got %h want f7", o_an);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 13'h1FFE) $display("FAIL rstmid_async got %h want %h", obs, 13'h1FFE);
    else passed++;
    model_reset();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      total++;
      if (obs !== expv) $display("FAIL rstmid c=%0d got %h want %h", c, obs, expv);
      else passed++;
      if (c == 2) begin
        total++;
        if (o_an !== 8'hFE) $display("FAIL rstmid_restart got %h want fe", o_an);
        else passed++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_lzb();
    test_back_to_back();
    test_digit_en();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
